// File: rtl/neopixel_tx_stream.sv
// WS281x/SK6812 serial transmitter streaming a runtime-selected number of
// pixels from a synchronous pixel RAM, with next-pixel prefetch, abort and
// busy/done status.
module neopixel_tx_stream #(
  parameter int unsigned BITS_PER_PIXEL = 24,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned T0H            = 3,
  parameter int unsigned T0L            = 9,
  parameter int unsigned T1H            = 6,
  parameter int unsigned T1L            = 6,
  parameter int unsigned TRESET         = 800
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [ADDR_W:0]           i_num_pixels,
  input  logic                      i_abort,
  output logic [ADDR_W-1:0]         o_mem_addr,
  input  logic [BITS_PER_PIXEL-1:0] i_mem_data,
  output logic                      o_led_out,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned NUM_W = ADDR_W + 1;
  localparam int unsigned BIT_W = $clog2(BITS_PER_PIXEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_LATCH = 3'd4
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [NUM_W-1:0]          r_num;
  logic [NUM_W-1:0]          r_pix;
  logic [BIT_W-1:0]          r_bit;
  logic [BITS_PER_PIXEL-1:0] r_sr;
  logic [BITS_PER_PIXEL-1:0] r_pf;
  logic                      r_pf_d1;
  logic                      r_pf_d2;
  logic [ADDR_W-1:0]         r_mem_addr;
  logic                      r_led;
  logic                      r_busy;
  logic                      r_done;

  state_t                    w_state_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [NUM_W-1:0]          w_num_nxt;
  logic [NUM_W-1:0]          w_pix_nxt;
  logic [BIT_W-1:0]          w_bit_nxt;
  logic [BITS_PER_PIXEL-1:0] w_sr_nxt;
  logic [BITS_PER_PIXEL-1:0] w_pf_nxt;
  logic                      w_pf_req;
  logic [ADDR_W-1:0]         w_addr_nxt;
  logic                      w_led_nxt;
  logic                      w_busy_nxt;
  logic                      w_done_nxt;

  // Phase-end and pixel-boundary decodes shared by both combinational blocks
  logic [CNT_W-1:0] w_high_last;
  logic [CNT_W-1:0] w_low_last;
  logic             w_fetch_end;
  logic             w_high_end;
  logic             w_low_end;
  logic             w_latch_end;
  logic             w_last_bit;
  logic             w_last_pix;
  logic [NUM_W-1:0] w_num_m1;
  logic [NUM_W-1:0] w_pix_p2;
  logic [NUM_W-1:0] w_addr_sat;

  assign w_high_last = r_sr[BITS_PER_PIXEL-1] ? CNT_W'(T1H - 1) : CNT_W'(T0H - 1);
  assign w_low_last  = r_sr[BITS_PER_PIXEL-1] ? CNT_W'(T1L - 1) : CNT_W'(T0L - 1);
  assign w_fetch_end = (r_cnt == CNT_W'(1));
  assign w_high_end  = (r_cnt == w_high_last);
  assign w_low_end   = (r_cnt == w_low_last);
  assign w_latch_end = (r_cnt == CNT_W'(TRESET - 1));
  assign w_last_bit  = (r_bit == BIT_W'(BITS_PER_PIXEL - 1));
  assign w_num_m1    = r_num - NUM_W'(1);
  assign w_last_pix  = (r_pix == w_num_m1);
  assign w_pix_p2    = r_pix + NUM_W'(2);
  // Prefetch address saturates at the last valid pixel index
  assign w_addr_sat  = (w_pix_p2 > w_num_m1) ? w_num_m1 : w_pix_p2;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort wins over any phase completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_num_pixels == '0) ? S_LATCH : S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_abort)          w_state_nxt = S_LATCH;
        else if (w_fetch_end) w_state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (i_abort)         w_state_nxt = S_LATCH;
        else if (w_high_end) w_state_nxt = S_LOW;
      end
      S_LOW: begin
        if (i_abort) begin
          w_state_nxt = S_LATCH;
        end else if (w_low_end) begin
          w_state_nxt = (w_last_bit && w_last_pix) ? S_LATCH : S_HIGH;
        end
      end
      S_LATCH: begin
        if (w_latch_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    w_cnt_nxt  = (r_state == S_IDLE || w_state_nxt != r_state) ? '0 : CNT_W'(r_cnt + CNT_W'(1));
    w_led_nxt  = (w_state_nxt == S_HIGH);
    w_num_nxt  = r_num;
    w_pix_nxt  = r_pix;
    w_bit_nxt  = r_bit;
    w_sr_nxt   = r_sr;
    w_pf_nxt   = r_pf_d2 ? i_mem_data : r_pf;
    w_pf_req   = 1'b0;
    w_addr_nxt = r_mem_addr;
    w_busy_nxt = r_busy;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_num_nxt  = i_num_pixels;
          w_pix_nxt  = '0;
          w_bit_nxt  = '0;
          w_addr_nxt = '0;
          w_busy_nxt = 1'b1;
        end
      end
      S_FETCH: begin
        if (!i_abort && w_fetch_end) begin
          w_sr_nxt   = i_mem_data;
          w_addr_nxt = (r_num > NUM_W'(1)) ? ADDR_W'(1) : '0;
          w_pf_req   = 1'b1;
        end
      end
      S_LOW: begin
        if (!i_abort && w_low_end) begin
          if (!w_last_bit) begin
            w_sr_nxt  = r_sr << 1;
            w_bit_nxt = BIT_W'(r_bit + BIT_W'(1));
          end else if (!w_last_pix) begin
            w_sr_nxt   = r_pf;
            w_bit_nxt  = '0;
            w_pix_nxt  = NUM_W'(r_pix + NUM_W'(1));
            w_addr_nxt = ADDR_W'(w_addr_sat);
            w_pf_req   = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (w_latch_end) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt      <= '0;
      r_num      <= '0;
      r_pix      <= '0;
      r_bit      <= '0;
      r_sr       <= '0;
      r_pf       <= '0;
      r_pf_d1    <= 1'b0;
      r_pf_d2    <= 1'b0;
      r_mem_addr <= '0;
      r_led      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_num      <= w_num_nxt;
      r_pix      <= w_pix_nxt;
      r_bit      <= w_bit_nxt;
      r_sr       <= w_sr_nxt;
      r_pf       <= w_pf_nxt;
      r_pf_d1    <= w_pf_req;
      r_pf_d2    <= r_pf_d1;
      r_mem_addr <= w_addr_nxt;
      r_led      <= w_led_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_mem_addr = r_mem_addr;
  assign o_led_out  = r_led;
  assign o_busy     = r_busy;
  assign o_done     = r_done;

endmodule

// File: tb/tb_neopixel_tx_stream.sv
// Bench for neopixel_tx_stream: 24-bit and 32-bit instances, each frame
// compared cycle by cycle against a waveform built from the pixel data.
module tb_neopixel_tx_stream;

  localparam int TRESET = 800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1, abort0, abort1;
  logic [8:0]  num0, num1;
  logic [7:0]  addr0, addr1;
  logic [31:0] rd0, rd1;
  logic        led0, led1, busy0, busy1, done0, done1;

  logic [31:0] ram [2][256];
  logic [2:0]  exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  neopixel_tx_stream u_dut24 (
    .i_clk(clk), .i_reset(rst), .i_start(start0), .i_num_pixels(num0),
    .i_abort(abort0), .o_mem_addr(addr0), .i_mem_data(rd0[23:0]),
    .o_led_out(led0), .o_busy(busy0), .o_done(done0)
  );

  neopixel_tx_stream #(.BITS_PER_PIXEL(32)) u_dut32 (
    .i_clk(clk), .i_reset(rst), .i_start(start1), .i_num_pixels(num1),
    .i_abort(abort1), .o_mem_addr(addr1), .i_mem_data(rd1),
    .o_led_out(led1), .o_busy(busy1), .o_done(done1)
  );

  // Synchronous pixel RAMs with one cycle of read latency
  always @(posedge clk) begin
    rd0 <= ram[0][addr0];
    rd1 <= ram[1][addr1];
  end

  function automatic logic [2:0] obs(input int sel);
    return (sel != 0) ? {led1, busy1, done1} : {led0, busy0, done0};
  endfunction

  function automatic logic [7:0] obs_addr(input int sel);
    return (sel != 0) ? addr1 : addr0;
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic ab, input logic [8:0] n);
    if (sel != 0) begin start1 = st; abort1 = ab; num1 = n; end
    else          begin start0 = st; abort0 = ab; num0 = n; end
  endtask

  // Expected {led, busy, done} per cycle after the accepted start edge
  task automatic build_exp(input int sel, input int n, input int abort_at);
    int bpp;
    logic [31:0] px;
    bpp = (sel != 0) ? 32 : 24;
    exp_q.delete();
    if (n > 0) begin
      repeat (2) exp_q.push_back(3'b010);
      for (int p = 0; p < n; p++) begin
        px = ram[sel][p];
        for (int b = bpp - 1; b >= 0; b--) begin
          repeat (px[b] ? 6 : 3) exp_q.push_back(3'b110);
          repeat (px[b] ? 6 : 9) exp_q.push_back(3'b010);
        end
      end
    end
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
    end
    repeat (TRESET) exp_q.push_back(3'b010);
    exp_q.push_back(3'b001);
  endtask

  // Start a frame at the current negedge and check every cycle through done
  task automatic run_frame(input int fid, input int sel, input int n, input int mid_start,
                           input int abort_at, input bit chain, input int next_n);
    int last;
    int lim;
    logic [8:0] cur_n;
    build_exp(sel, n, abort_at);
    last = exp_q.size() - 1;
    lim = (n > 0) ? n - 1 : 0;
    cur_n = 9'(n);
    drive(sel, 1'b1, 1'b0, cur_n);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, cur_n);
    for (int i = 0; i <= last; i++) begin
      check($sformatf("f%0d wave c%0d", fid, i), 32'(obs(sel)), 32'(exp_q[i]));
      check($sformatf("f%0d addr c%0d", fid, i), 32'(int'(obs_addr(sel)) <= lim), 32'd1);
      if (i == mid_start) cur_n = 9'd5;
      if (chain && i == last) cur_n = 9'(next_n);
      drive(sel, (i == mid_start) || (chain && i == last), i == abort_at, cur_n);
      if (i != last) @(negedge clk);
    end
    drive(sel, chain, 1'b0, cur_n);
  endtask

  task automatic idle(input int sel, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check($sformatf("idle s%0d c%0d", sel, i), 32'(obs(sel)), 32'd0);
    end
  endtask

  initial begin
    int sel, n, ab, nbits;
    rst = 1'b1;
    start0 = 0; start1 = 0; abort0 = 0; abort1 = 0; num0 = '0; num1 = '0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a++) ram[s][a] = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset outs s%0d", s), 32'(obs(s)), 32'd0);
      check($sformatf("reset addr s%0d", s), 32'(obs_addr(s)), 32'd0);
    end
    rst = 1'b0;
    idle(0, 2);

    // Single pixel, mixed bit values
    ram[0][0] = 32'h800001;
    run_frame(1, 0, 1, -1, -1, 0, 0);
    idle(0, 3);

    // Three pixels back to back, with an ignored mid-frame start
    ram[0][0] = 32'hFF0000; ram[0][1] = 32'h00FF00; ram[0][2] = 32'h0000FF;
    run_frame(2, 0, 3, 200, -1, 0, 0);
    idle(0, 3);

    // RGBW instance
    ram[1][0] = 32'h12345678; ram[1][1] = 32'h9ABCDEF0;
    run_frame(3, 1, 2, -1, -1, 0, 0);
    idle(1, 3);

    // Start held through done: second frame follows immediately
    ram[0][0] = $urandom() & 32'hFFFFFF; ram[0][1] = $urandom() & 32'hFFFFFF;
    run_frame(4, 0, 2, -1, -1, 1, 1);
    run_frame(5, 0, 1, -1, -1, 0, 0);
    idle(0, 3);

    // Zero-length frame
    run_frame(6, 0, 0, -1, -1, 0, 0);
    idle(0, 3);

    // Abort in the second cycle of pixel 1 bit 5 high phase
    for (int p = 0; p < 3; p++) ram[0][p] = $urandom() & 32'hFFFFFF;
    run_frame(7, 0, 3, -1, 2 + 12 * (24 + 5) + 1, 0, 0);
    idle(0, 3);

    // Asynchronous reset in the middle of a high phase
    ram[0][0] = $urandom() & 32'hFFFFFF; ram[0][1] = $urandom() & 32'hFFFFFF;
    build_exp(0, 2, -1);
    drive(0, 1'b1, 1'b0, 9'd2);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 9'd2);
    repeat (2 + 12 * 3 + 1) @(negedge clk);
    check("pre-reset led", 32'(led0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async reset outs", 32'(obs(0)), 32'd0);
    check("async reset addr", 32'(addr0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(0, 5);
    run_frame(8, 0, 2, -1, -1, 0, 0);
    idle(0, 2);

    // Randomised frames on both widths, some aborted
    for (int f = 0; f < 6; f++) begin
      sel = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 4));
      for (int p = 0; p < n; p++)
        ram[sel][p] = (sel != 0) ? $urandom() : ($urandom() & 32'hFFFFFF);
      nbits = n * ((sel != 0) ? 32 : 24);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2 + 12 * nbits - 1)) : -1;
      run_frame(10 + f, sel, n, -1, ab, 0, 0);
      idle(sel, 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
